// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: datapath width, opcode encodings
// and the legal-opcode test used when tagging FIFO entries.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream issue and downstream result handshakes of alu_issue_stage.
// Optional ALU_FLAGS_EN adds the per-result zero/overflow flags.
interface alu_issue_stage_if #(parameter int WIDTH = alu_pkg::ALU_WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_z;
    logic             out_err;
    logic             busy;
`ifdef ALU_FLAGS_EN
    logic             out_zero;
    logic             out_ovf;
`endif

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_z, out_err, busy
`ifdef ALU_FLAGS_EN
        , input out_zero, out_ovf
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_z, out_err, busy
`ifdef ALU_FLAGS_EN
        , output out_zero, out_ovf
`endif
    );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU core: AND, OR, ADD, SUB; other opcodes yield zero.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] z
);

    always_comb begin
        z = '0;
        case (op)
            OP_AND:  z = a & b;
            OP_OR:   z = a | b;
            OP_ADD:  z = a + b;
            OP_SUB:  z = a + ~b + WIDTH'(1);
            default: z = '0;
        endcase
    end

endmodule

// File: rtl/alu_result_fifo.sv
// DEPTH-entry synchronous FIFO with occupancy count; pointers wrap naturally,
// full/empty come from the separate count. Asynchronous active-low reset.
module alu_result_fifo #(
    parameter int DATA_W = 33,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign push_ok = push && (count != FULL_CNT);
    assign pop_ok  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue/result stage around the combinational ALU: accepted operands
// are evaluated and captured into a small result FIFO. Optional macro ALU_FLAGS_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_stage_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
`ifdef ALU_FLAGS_EN
    localparam int ENTRY_W = WIDTH + 3;
`else
    localparam int ENTRY_W = WIDTH + 1;
`endif

    logic               ready_en;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   alu_z;
    logic [WIDTH-1:0]   store_z;
    logic               legal;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] rdata;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a  (bus.in_a),
        .b  (bus.in_b),
        .op (bus.in_op),
        .z  (alu_z)
    );

    // in_ready stays low during reset and rises on the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign legal   = is_legal_op(bus.in_op);
    assign store_z = legal ? alu_z : '0;

`ifdef ALU_FLAGS_EN
    logic zero_flag;
    logic ovf_flag;

    always_comb begin
        zero_flag = (store_z == '0);
        ovf_flag  = 1'b0;
        if (bus.in_op == OP_ADD) begin
            ovf_flag = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                       (store_z[WIDTH-1] != bus.in_a[WIDTH-1]);
        end else if (bus.in_op == OP_SUB) begin
            ovf_flag = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                       (store_z[WIDTH-1] != bus.in_a[WIDTH-1]);
        end
    end

    assign wdata = {ovf_flag, zero_flag, ~legal, store_z};
`else
    assign wdata = {~legal, store_z};
`endif

    assign bus.in_ready  = ready_en && (count < FULL_CNT);
    assign bus.out_valid = (count != '0);
    assign bus.busy      = (count != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    alu_result_fifo #(.DATA_W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .count (count)
    );

    // Head fields are masked to zero whenever the FIFO is empty.
    assign bus.out_z   = bus.out_valid ? rdata[WIDTH-1:0] : '0;
    assign bus.out_err = bus.out_valid && rdata[WIDTH];
`ifdef ALU_FLAGS_EN
    assign bus.out_zero = bus.out_valid && rdata[WIDTH+1];
    assign bus.out_ovf  = bus.out_valid && rdata[WIDTH+2];
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage; flag checks compile in with ALU_FLAGS_EN.
module tb_alu_issue_stage;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   passed = 0;

    alu_issue_stage_if #(.WIDTH(32)) bus ();

    alu_issue_stage #(.WIDTH(32), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one transaction and hold it until accepted (bounded).
    task automatic issue_one(input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op, output bit ok);
        @(negedge clk);
        bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_valid = 1'b1;
        for (int n = 0; n < 20 && !bus.in_ready; n++) @(negedge clk);
        ok = bus.in_ready;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Drain the head entry (bounded wait for out_valid).
    task automatic pop_one(output logic [31:0] z, output logic err, output bit ok);
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int n = 0; n < 20 && !bus.out_valid; n++) @(negedge clk);
        ok  = bus.out_valid;
        z   = bus.out_z;
        err = bus.out_err;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0;
        bus.out_ready = 1'b0;
        #12;
        checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL rst_in_ready got=%b exp=0", bus.in_ready); else passed++;
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL rst_out_valid got=%b exp=0", bus.out_valid); else passed++;
        checks++; if (bus.out_z !== 32'h0) $display("[TB] FAIL rst_out_z got=%h exp=0", bus.out_z); else passed++;
        checks++; if (bus.out_err !== 1'b0) $display("[TB] FAIL rst_out_err got=%b exp=0", bus.out_err); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL rst_busy got=%b exp=0", bus.busy); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL rel_in_ready_pre_edge got=%b exp=0", bus.in_ready); else passed++;
        @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL rel_in_ready_post_edge got=%b exp=1", bus.in_ready); else passed++;
    endtask

    task automatic test_single_add;
        bit ok;
        issue_one(32'h7FFF_FFFF, 32'h1, 3'b010, ok);
        @(negedge clk);
        checks++; if (!ok || bus.out_valid !== 1'b1) $display("[TB] FAIL add_valid got=%b exp=1", bus.out_valid); else passed++;
        checks++; if (bus.out_z !== 32'h8000_0000) $display("[TB] FAIL add_z got=%h exp=80000000", bus.out_z); else passed++;
        checks++; if (bus.out_err !== 1'b0) $display("[TB] FAIL add_err got=%b exp=0", bus.out_err); else passed++;
`ifdef ALU_FLAGS_EN
        checks++; if (bus.out_ovf !== 1'b1) $display("[TB] FAIL add_ovf got=%b exp=1", bus.out_ovf); else passed++;
        checks++; if (bus.out_zero !== 1'b0) $display("[TB] FAIL add_zero got=%b exp=0", bus.out_zero); else passed++;
`endif
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) $display("[TB] FAIL add_drained got=%b exp=0", bus.out_valid); else passed++;
    endtask

    task automatic test_logic_ops;
        logic [31:0] va [3] = '{32'h0, 32'hF0F0_F0F0, 32'hF0F0_F0F0};
        logic [31:0] vb [3] = '{32'h1, 32'hFF00_FF00, 32'hFF00_FF00};
        logic [2:0]  vo [3] = '{3'b110, 3'b000, 3'b001};
        logic [31:0] ve [3] = '{32'hFFFF_FFFF, 32'hF000_F000, 32'hFFF0_FFF0};
        logic [31:0] z;
        logic        err;
        bit          ok_i, ok_p;
        for (int i = 0; i < 3; i++) begin
            issue_one(va[i], vb[i], vo[i], ok_i);
            pop_one(z, err, ok_p);
            checks++;
            if (!ok_i || !ok_p || z !== ve[i] || err !== 1'b0)
                $display("[TB] FAIL op_vec%0d got z=%h err=%b exp z=%h err=0", i, z, err, ve[i]);
            else passed++;
        end
    endtask

    task automatic test_back_pressure;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_a = 32'd1; bus.in_b = 32'd1; bus.in_op = 3'b010; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_a = 32'd2; bus.in_b = 32'd2;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL bp_ready_one got=%b exp=1", bus.in_ready); else passed++;
        @(posedge clk);
        #1 bus.in_a = 32'd3; bus.in_b = 32'd3;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL bp_full got=%b exp=0", bus.in_ready); else passed++;
        checks++; if (bus.out_z !== 32'd2) $display("[TB] FAIL bp_head got=%0d exp=2", bus.out_z); else passed++;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0 || bus.out_z !== 32'd2) $display("[TB] FAIL bp_hold got rdy=%b z=%0d exp rdy=0 z=2", bus.in_ready, bus.out_z); else passed++;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.out_z !== 32'd4 || bus.in_ready !== 1'b1) $display("[TB] FAIL bp_second got z=%0d rdy=%b exp z=4 rdy=1", bus.out_z, bus.in_ready); else passed++;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_z !== 32'd6) $display("[TB] FAIL bp_third got v=%b z=%0d exp v=1 z=6", bus.out_valid, bus.out_z); else passed++;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL bp_empty got=%b exp=0", bus.out_valid); else passed++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus.in_a = 32'd100; bus.in_b = 32'd0; bus.in_op = 3'b010;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (i < 7) begin
                bus.in_a = 32'(100 + i + 1);
                bus.in_b = 32'(i + 1);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_z !== 32'(100 + 2 * i))
                $display("[TB] FAIL b2b_%0d got v=%b rdy=%b z=%0d exp v=1 rdy=1 z=%0d",
                         i, bus.out_valid, bus.in_ready, bus.out_z, 100 + 2 * i);
            else passed++;
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL b2b_drained got=%b exp=0", bus.out_valid); else passed++;
    endtask

    task automatic test_illegal_op;
        logic [31:0] z;
        logic        err;
        bit          ok_i, ok_p;
        issue_one(32'd5, 32'd3, 3'b101, ok_i);
        @(negedge clk);
        checks++; if (!ok_i || bus.busy !== 1'b1) $display("[TB] FAIL ill_slot got=%b exp=1", bus.busy); else passed++;
        pop_one(z, err, ok_p);
        checks++; if (!ok_p || z !== 32'h0 || err !== 1'b1) $display("[TB] FAIL ill_entry got z=%h err=%b exp z=0 err=1", z, err); else passed++;
        issue_one(32'd5, 32'd3, 3'b010, ok_i);
        pop_one(z, err, ok_p);
        checks++; if (!ok_i || !ok_p || z !== 32'd8 || err !== 1'b0) $display("[TB] FAIL ill_next got z=%0d err=%b exp z=8 err=0", z, err); else passed++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] z;
        logic        err;
        bit          ok_i, ok_p;
        bus.out_ready = 1'b0;
        issue_one(32'd11, 32'd1, 3'b010, ok_i);
        issue_one(32'd22, 32'd2, 3'b010, ok_p);
        @(negedge clk);
        checks++; if (!ok_i || !ok_p || bus.in_ready !== 1'b0) $display("[TB] FAIL mid_full got=%b exp=0", bus.in_ready); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0)
            $display("[TB] FAIL mid_async got v=%b busy=%b rdy=%b exp 0 0 0", bus.out_valid, bus.busy, bus.in_ready);
        else passed++;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) $display("[TB] FAIL mid_after got rdy=%b v=%b exp rdy=1 v=0", bus.in_ready, bus.out_valid); else passed++;
        issue_one(32'd10, 32'd20, 3'b010, ok_i);
        pop_one(z, err, ok_p);
        checks++; if (!ok_i || !ok_p || z !== 32'd30 || err !== 1'b0) $display("[TB] FAIL mid_first got z=%0d err=%b exp z=30 err=0", z, err); else passed++;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL mid_no_stale got=%b exp=0", bus.out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_logic_ops();
        test_back_pressure();
        test_back_to_back();
        test_illegal_op();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
